// File: rtl/sipo_shift_register_pkg.sv
// Shared definitions for the serial-in, parallel-out shift register and
// the logic that consumes its parallel word.
package sipo_shift_register_pkg;

   // Default register length in bits.
   localparam int SIPO_DEFAULT_WIDTH = 4;

   // Word type at the default width, so consumers use the same type.
   typedef logic [SIPO_DEFAULT_WIDTH-1:0] sipo_word_t;

   // Reset contents at the default width.
   localparam sipo_word_t SIPO_DEFAULT_RESET = '0;

endpackage : sipo_shift_register_pkg

// File: rtl/sipo_shift_register.sv
// Serial-in, parallel-out shift register. A new bit enters at bit 0 on
// every rising edge and older bits move toward the MSB. The oldest bit
// falls off the top. There is no enable and no framing, so the consumer
// is responsible for word alignment. The parallel output comes straight
// from flops, with no combinational path from serial_in.
//
// WIDTH must be at least 2.
module sipo_shift_register
   import sipo_shift_register_pkg::*;
#(
   parameter int               WIDTH       = SIPO_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   output logic [WIDTH-1:0] parallel_out
);

   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;

   // Next contents: drop the MSB and append the incoming bit at bit 0.
   always_comb begin
      shift_d = {shift_q[WIDTH-2:0], serial_in};
   end

   // Register update. Reset has priority and ignores serial_in on its edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= RESET_VALUE;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign parallel_out = shift_q;

endmodule : sipo_shift_register

// File: tb/tb_sipo_shift_register.sv
// Directed testbench for sipo_shift_register. It checks a default 4-bit
// instance and an 8-bit instance that uses a non-zero reset value.
module tb_sipo_shift_register;

   logic       clk;
   logic       reset;
   logic       serial_in;
   logic [3:0] parallel_out;

   logic       reset8;
   logic       serial_in8;
   logic [7:0] parallel_out8;

   int checks;
   int errors;

   sipo_shift_register #(
      .WIDTH       (4),
      .RESET_VALUE (4'b0000)
   ) dut4 (
      .clk          (clk),
      .reset        (reset),
      .serial_in    (serial_in),
      .parallel_out (parallel_out)
   );

   sipo_shift_register #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) dut8 (
      .clk          (clk),
      .reset        (reset8),
      .serial_in    (serial_in8),
      .parallel_out (parallel_out8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives the 4-bit instance before an edge, then waits until 1 time unit after the edge.
   task automatic drive4(input logic r, input logic b);
      @(negedge clk);
      reset     = r;
      serial_in = b;
      @(posedge clk);
      #1;
   endtask

   // Drives the 8-bit instance before an edge, then waits until 1 time unit after the edge.
   task automatic drive8(input logic r, input logic b);
      @(negedge clk);
      reset8     = r;
      serial_in8 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // The first edge, at time 5, has reset high and serial_in=1 (ignored).
      @(posedge clk);
      #1;
      checks++;
      if (parallel_out !== 4'b0000) begin
         errors++;
         $display("FAIL reset_first_edge: got %b expected %b", parallel_out, 4'b0000);
      end
      drive4(1'b1, 1'b1);
      checks++;
      if (parallel_out !== 4'b0000) begin
         errors++;
         $display("FAIL reset_held: got %b expected %b", parallel_out, 4'b0000);
      end
      $display("reset: parallel_out=%b", parallel_out);
   endtask

   task automatic test_first_word();
      logic [4:0] bits;
      logic [3:0] exp [5];
      bits = 5'b01011;   // bits[4] is driven first
      exp[0] = 4'b0000; exp[1] = 4'b0001; exp[2] = 4'b0010;
      exp[3] = 4'b0101; exp[4] = 4'b1011;
      for (int i = 0; i < 5; i++) begin
         drive4(1'b0, bits[4-i]);
         checks++;
         if (parallel_out !== exp[i]) begin
            errors++;
            $display("FAIL first_word[%0d]: got %b expected %b", i, parallel_out, exp[i]);
         end
         $display("first_word: in=%b out=%b", bits[4-i], parallel_out);
      end
   endtask

   task automatic test_continued_stream();
      logic [5:0] bits;
      logic [3:0] exp [6];
      bits = 6'b101000;
      exp[0] = 4'b0111; exp[1] = 4'b1110; exp[2] = 4'b1101;
      exp[3] = 4'b1010; exp[4] = 4'b0100; exp[5] = 4'b1000;
      for (int i = 0; i < 6; i++) begin
         drive4(1'b0, bits[5-i]);
         checks++;
         if (parallel_out !== exp[i]) begin
            errors++;
            $display("FAIL continued[%0d]: got %b expected %b", i, parallel_out, exp[i]);
         end
         $display("continued: in=%b out=%b", bits[5-i], parallel_out);
      end
   endtask

   task automatic test_mid_stream_reset();
      // Shifting 0,1,0,1 into 1000 gives 0101.
      drive4(1'b0, 1'b0);
      drive4(1'b0, 1'b1);
      drive4(1'b0, 1'b0);
      drive4(1'b0, 1'b1);
      checks++;
      if (parallel_out !== 4'b0101) begin
         errors++;
         $display("FAIL mid_reset_load: got %b expected %b", parallel_out, 4'b0101);
      end
      drive4(1'b1, 1'b1);
      checks++;
      if (parallel_out !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_clear: got %b expected %b", parallel_out, 4'b0000);
      end
      drive4(1'b0, 1'b1);
      checks++;
      if (parallel_out !== 4'b0001) begin
         errors++;
         $display("FAIL mid_reset_resume: got %b expected %b", parallel_out, 4'b0001);
      end
      $display("mid_reset: out=%b", parallel_out);
   endtask

   task automatic test_saturation();
      logic [3:0] exp [10];
      exp[0] = 4'b0001; exp[1] = 4'b0011; exp[2] = 4'b0111; exp[3] = 4'b1111;
      exp[4] = 4'b1111; exp[5] = 4'b1111; exp[6] = 4'b1110; exp[7] = 4'b1100;
      exp[8] = 4'b1000; exp[9] = 4'b0000;
      drive4(1'b1, 1'b0);
      checks++;
      if (parallel_out !== 4'b0000) begin
         errors++;
         $display("FAIL sat_reset: got %b expected %b", parallel_out, 4'b0000);
      end
      for (int i = 0; i < 10; i++) begin
         drive4(1'b0, (i < 6) ? 1'b1 : 1'b0);
         checks++;
         if (parallel_out !== exp[i]) begin
            errors++;
            $display("FAIL saturation[%0d]: got %b expected %b", i, parallel_out, exp[i]);
         end
         $display("saturation: out=%b", parallel_out);
      end
   endtask

   task automatic test_width8();
      logic [7:0] word;
      word = 8'b10110011;
      drive8(1'b1, 1'b0);
      checks++;
      if (parallel_out8 !== 8'hA5) begin
         errors++;
         $display("FAIL w8_reset_value: got %h expected %h", parallel_out8, 8'hA5);
      end
      for (int i = 0; i < 8; i++) begin
         drive8(1'b0, word[7-i]);
         // After 4 bits, the upper half of A5 has shifted out: 0101_1011.
         if (i == 3) begin
            checks++;
            if (parallel_out8 !== 8'h5B) begin
               errors++;
               $display("FAIL w8_half: got %h expected %h", parallel_out8, 8'h5B);
            end
         end
         $display("width8: in=%b out=%b", word[7-i], parallel_out8);
      end
      checks++;
      if (parallel_out8 !== 8'b10110011) begin
         errors++;
         $display("FAIL w8_full: got %b expected %b", parallel_out8, 8'b10110011);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      serial_in  = 1'b1;
      reset8     = 1'b1;
      serial_in8 = 1'b0;
      test_reset();
      test_first_word();
      test_continued_stream();
      test_mid_stream_reset();
      test_saturation();
      test_width8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sipo_shift_register
